// File: rtl/brc_cmp_arbiter.sv
// Two-requester branch comparator sharing one unsigned subtract-based compare unit.
// Round-robin arbitration; each transaction runs IDLE -> CMP -> RESP.

module brc_cmp_unsigned #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt
);
  logic [XLEN:0] diff;

  // The borrow out of the widened subtraction is the unsigned a < b.
  assign diff = {1'b0, a} - {1'b0, b};
  assign lt   = diff[XLEN];
  assign eq   = (diff[XLEN-1:0] == '0);
endmodule

module brc_cmp_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [XLEN-1:0] i_rs1_data_0,
  input  logic [XLEN-1:0] i_rs2_data_0,
  input  logic [XLEN-1:0] i_rs1_data_1,
  input  logic [XLEN-1:0] i_rs2_data_1,
  input  logic [1:0]      i_br_un,
  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic            o_br_equal,
  output logic            o_br_less,
  input  logic            i_rsp_ready,
  output logic [1:0]      o_dbg_state
);
  // Handshake: a transfer happens in a cycle where valid and ready are both 1;
  // ready never depends on anything but state, pointer and valid, and a source
  // holds valid and its payload stable until the transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic            un_q, un_d;
  logic            id_q, id_d;
  logic            rid_q, rid_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  logic [1:0]      grant;
  logic            sel;
  logic [XLEN-1:0] sign_flip;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic            cmp_eq, cmp_lt;

  // Flipping the sign bit maps signed order onto unsigned order.
  assign sign_flip = {1'b1, {(XLEN-1){1'b0}}} & {XLEN{~un_q}};
  assign cmp_a     = rs1_q ^ sign_flip;
  assign cmp_b     = rs2_q ^ sign_flip;

  brc_cmp_unsigned #(.XLEN(XLEN)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    un_d    = un_q;
    id_d    = id_q;
    rid_d   = rid_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    grant   = 2'b00;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
        else                      grant = i_req_valid;
        if (grant != 2'b00) begin
          sel     = grant[1];
          rs1_d   = sel ? i_rs1_data_1 : i_rs1_data_0;
          rs2_d   = sel ? i_rs2_data_1 : i_rs2_data_0;
          un_d    = i_br_un[sel];
          id_d    = sel;
          ptr_d   = ~sel;
          state_d = CMP;
        end
      end
      CMP: begin
        eq_d    = cmp_eq;
        lt_d    = cmp_lt;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      un_q    <= 1'b0;
      id_q    <= 1'b0;
      rid_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      un_q    <= un_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // Ready is masked by reset so no grant is offered while reset is held.
  assign o_req_ready = i_rst_n ? grant : 2'b00;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id    = rid_q;
  assign o_br_equal  = eq_q;
  assign o_br_less   = lt_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_brc_cmp_arbiter.sv
// Directed bench for brc_cmp_arbiter: reset, arbitration, signedness,
// backpressure and mid-operation reset, checked with immediate assertions.

module tb_brc_cmp_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] rs1_0, rs2_0, rs1_1, rs2_1;
  logic [1:0]  br_un;
  logic        rsp_valid, rsp_id, br_equal, br_less;
  logic        rsp_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  brc_cmp_arbiter #(.XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_rs1_data_0 (rs1_0),
    .i_rs2_data_0 (rs2_0),
    .i_rs1_data_1 (rs1_1),
    .i_rs2_data_1 (rs2_1),
    .i_br_un      (br_un),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_br_equal   (br_equal),
    .o_br_less    (br_less),
    .i_rsp_ready  (rsp_ready),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic eq, input logic lt);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_id"},    {31'b0, rsp_id},    {31'b0, id});
    chk({tag, "_eq"},    {31'b0, br_equal},  {31'b0, eq});
    chk({tag, "_lt"},    {31'b0, br_less},   {31'b0, lt});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rs1_0 = 32'd5;          rs2_0 = 32'd7;
    rs1_1 = 32'hFFFF_FFFF;  rs2_1 = 32'h0000_0001;
    br_un     = 2'b01;
    rsp_ready = 1'b1;

    // reset held with both requests active
    repeat (3) next_cycle();
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id",    {31'b0, rsp_id},    32'd0);
    chk("rst_eq",    {31'b0, br_equal},  32'd0);
    chk("rst_lt",    {31'b0, br_less},   32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);

    // release: requester 0 granted first (unsigned 5 < 7)
    rst_n = 1'b1;
    #1;
    chk("c0_ready", {30'b0, req_ready}, 32'h1);
    next_cycle();
    chk("c1_state", {30'b0, dbg_state}, 32'd1);
    chk("c1_ready", {30'b0, req_ready}, 32'd0);
    chk("c1_rspv",  {31'b0, rsp_valid}, 32'd0);
    next_cycle();
    chk_rsp("c2", 1'b0, 1'b0, 1'b1);
    chk("c2_ready", {30'b0, req_ready}, 32'd0);

    // pointer moved to 1: requester 1 wins contention (signed -1 < 1)
    next_cycle();
    chk("c3_ready", {30'b0, req_ready}, 32'h2);
    chk("c3_hold_lt", {31'b0, br_less}, 32'd1);
    chk("c3_rspv",  {31'b0, rsp_valid}, 32'd0);
    next_cycle();
    chk("c4_hold_lt", {31'b0, br_less}, 32'd1);
    next_cycle();
    chk_rsp("c5", 1'b1, 1'b0, 1'b1);

    // back to 0 under contention, then drop both requests
    next_cycle();
    chk("c6_ready", {30'b0, req_ready}, 32'h1);
    req_valid = 2'b00;
    #1;
    chk("drop_ready", {30'b0, req_ready}, 32'd0);
    next_cycle();
    chk("drop_state", {30'b0, dbg_state}, 32'd0);

    // lone requester 1 with pointer 0, unsigned 0xFFFFFFFF vs 1
    br_un = 2'b10;
    req_valid = 2'b10;
    #1;
    chk("lone1_p0_ready", {30'b0, req_ready}, 32'h2);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    chk_rsp("uns1", 1'b1, 1'b0, 1'b0);

    // requester 0 signed 0x80000000 < 0x7FFFFFFF, with backpressure
    next_cycle();
    rsp_ready = 1'b0;
    rs1_0 = 32'h8000_0000; rs2_0 = 32'h7FFF_FFFF;
    br_un = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("bp_ready", {30'b0, req_ready}, 32'h1);
    next_cycle();
    req_valid = 2'b11;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      chk_rsp($sformatf("bp%0d", i), 1'b0, 1'b0, 1'b1);
      chk($sformatf("bp%0d_ready", i), {30'b0, req_ready}, 32'd0);
      next_cycle();
    end
    chk_rsp("bp_last", 1'b0, 1'b0, 1'b1);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    next_cycle();
    chk("bp_done", {30'b0, dbg_state}, 32'd0);

    // lone requester 1 with pointer 1, signed 0x80000000 == 0x80000000
    rs1_1 = 32'h8000_0000; rs2_1 = 32'h8000_0000;
    req_valid = 2'b10;
    #1;
    chk("lone1_p1_ready", {30'b0, req_ready}, 32'h2);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    chk_rsp("eq1", 1'b1, 1'b1, 1'b0);

    // mid-operation reset while in CMP
    next_cycle();
    rs1_0 = 32'd9; rs2_0 = 32'd2; br_un = 2'b01;
    req_valid = 2'b01;
    next_cycle();
    req_valid = 2'b00;
    chk("mr_cmp", {30'b0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_state", {30'b0, dbg_state}, 32'd0);
    chk("mr_id",    {31'b0, rsp_id},    32'd0);
    chk("mr_eq",    {31'b0, br_equal},  32'd0);
    chk("mr_lt",    {31'b0, br_less},   32'd0);
    chk("mr_rspv",  {31'b0, rsp_valid}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk($sformatf("mr_stale%0d", i), {31'b0, rsp_valid}, 32'd0);
    end
    // pointer cleared by reset: requester 0 wins contention
    req_valid = 2'b11;
    #1;
    chk("mr_ptr", {30'b0, req_ready}, 32'h1);
    req_valid = 2'b00;

    // final report
    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
